// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: FSM states, parity modes and
// the baud-divider helpers also used by the receiver.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // A divider of 1 still needs a 1-bit counter.
  function automatic int cnt_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/count; the read data is the
// head entry (show-ahead), so a pop and its data use the same edge.
module sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam logic [ADDR_BITS:0] DEPTH = {1'b1, {ADDR_BITS{1'b0}}};

  logic [WIDTH-1:0]     mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   count;
  logic [ADDR_BITS:0]   count_next;
  logic                 do_wr;
  logic                 do_rd;

  // full/empty are registered, so a write while full is dropped even if a pop
  // happens on the same edge.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign dout  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_wr && !do_rd) begin
      count_next = count + 1'b1;
    end else if (!do_wr && do_rd) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == DEPTH);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: bytes queue in a FIFO and leave LSB first as
// start / data / optional parity / stop, every bit held BAUD_DIV clocks.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int SYS_CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE      = 38400,
  parameter int DATA_BITS      = 8,
  parameter int STOP_BITS      = 1,
  parameter int PARITY_MODE    = 0,
  parameter int FIFO_ADDR_BITS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  localparam int             BAUD_DIV  = baud_div(SYS_CLK_FREQ, BAUD_RATE);
  localparam int             CW        = cnt_width(BAUD_DIV);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [2:0]     DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [7:0]     DATA_MASK = 8'((1 << DATA_BITS) - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    data;
  logic [7:0]    fifo_dout;
  logic          pop;
  logic          tick;
  logic          parity_bit;
  logic          tx_next;

  sync_fifo #(
    .WIDTH    (8),
    .ADDR_BITS(FIFO_ADDR_BITS)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .rd_en(pop),
    .din  (din),
    .dout (fifo_dout),
    .full (full),
    .empty(empty)
  );

  assign tick       = (baud_cnt == BAUD_LAST);
  assign parity_bit = (PARITY_MODE == PARITY_ODD) ? ~^data : ^data;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (tick) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (tick && bit_cnt == DATA_LAST) begin
          state_next = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (tick) state_next = ST_STOP;
      end
      ST_STOP: begin
        // A queued byte chains straight into the next start bit.
        if (tick && bit_cnt == STOP_LAST) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_next = 1'b1;
    case (state)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift[0];
      ST_PARITY: tx_next = parity_bit;
      default:   tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      data     <= '0;
    end else begin
      if (state == ST_IDLE || tick) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
      if (tick) begin
        if (state_next != state) begin
          bit_cnt <= '0;
        end else if (state == ST_DATA || state == ST_STOP) begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
      if (pop) begin
        shift <= fifo_dout & DATA_MASK;
        data  <= fifo_dout & DATA_MASK;
      end else if (state == ST_DATA && tick) begin
        shift <= {1'b0, shift[7:1]};
      end
    end
  end

  // Outputs are registered one clock behind the state so tx never sees an
  // input combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx       <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      tx       <= tx_next;
      busy     <= (state != ST_IDLE);
      overflow <= wr_en && full;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, 8E1, 8O1, 7N2) at BAUD_DIV=16,
// line decoders checking every frame against hand-computed bit patterns.
module tb_uart_tx;

  localparam int BD = 16;
  localparam int W  = 16;  // {id[1:0], gap[1:0], frame[11:0]}; gap 3 = don't care

  logic       clk;
  logic       rst_n_v    [4];
  logic       wr_en_v    [4];
  logic [7:0] din_v      [4];
  logic       full_v     [4];
  logic       empty_v    [4];
  logic       busy_v     [4];
  logic       overflow_v [4];
  logic       tx_v       [4];

  int n_checks;
  int n_pass;
  int cyc;

  logic [W-1:0] exp_q[$];

  uart_tx #(.SYS_CLK_FREQ(16), .BAUD_RATE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n_v[0]), .wr_en(wr_en_v[0]), .din(din_v[0]),
    .full(full_v[0]), .empty(empty_v[0]), .busy(busy_v[0]),
    .overflow(overflow_v[0]), .tx(tx_v[0]));

  uart_tx #(.SYS_CLK_FREQ(16), .BAUD_RATE(1), .PARITY_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n_v[1]), .wr_en(wr_en_v[1]), .din(din_v[1]),
    .full(full_v[1]), .empty(empty_v[1]), .busy(busy_v[1]),
    .overflow(overflow_v[1]), .tx(tx_v[1]));

  uart_tx #(.SYS_CLK_FREQ(16), .BAUD_RATE(1), .PARITY_MODE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n_v[2]), .wr_en(wr_en_v[2]), .din(din_v[2]),
    .full(full_v[2]), .empty(empty_v[2]), .busy(busy_v[2]),
    .overflow(overflow_v[2]), .tx(tx_v[2]));

  uart_tx #(.SYS_CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(7), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n_v[3]), .wr_en(wr_en_v[3]), .din(din_v[3]),
    .full(full_v[3]), .empty(empty_v[3]), .busy(busy_v[3]),
    .overflow(overflow_v[3]), .tx(tx_v[3]));

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Frame bit i is the line level during bit period i (start first).
  function automatic logic [11:0] frame_8n1(input logic [7:0] b);
    return {2'b00, 1'b1, b, 1'b0};
  endfunction

  task automatic push_exp(input logic [1:0] id, input logic [1:0] gap, input logic [11:0] frame);
    exp_q.push_back({id, gap, frame});
  endtask

  function automatic int find_exp(input logic [1:0] id);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i][15:14] == id) return i;
    end
    return -1;
  endfunction

  function automatic int pending(input logic [1:0] id);
    int n = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i][15:14] == id) n++;
    end
    return n;
  endfunction

  // Line decoder: samples every clock of every bit, so bit length, hold and
  // the gap after the previous frame are all checked.
  task automatic monitor(input logic [1:0] id, input int nbits);
    logic [11:0]  got;
    logic [W-1:0] e;
    logic         bitv;
    logic         hold_ok;
    logic         aborted;
    int           start_cyc;
    int           prev_end;
    int           idx;
    prev_end = -100000;
    bitv     = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n_v[id] && !tx_v[id]) begin
        start_cyc = cyc;
        got       = '0;
        hold_ok   = 1'b1;
        aborted   = 1'b0;
        for (int b = 0; b < nbits && !aborted; b++) begin
          for (int c = 0; c < BD; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (!rst_n_v[id]) begin
              aborted = 1'b1;
              break;
            end
            if (c == 0) begin
              bitv   = tx_v[id];
              got[b] = bitv;
            end else if (tx_v[id] !== bitv) begin
              hold_ok = 1'b0;
            end
          end
        end
        idx = find_exp(id);
        if (idx < 0) begin
          check($sformatf("unexpected frame dut%0d", id), 32'(got), 32'hFFFF_FFFF);
        end else begin
          e = exp_q[idx];
          exp_q.delete(idx);
          if (!aborted) begin
            check($sformatf("frame dut%0d", id), 32'(got), 32'(e[11:0]));
            check($sformatf("bit hold dut%0d", id), 32'(hold_ok), 32'd1);
            if (e[13:12] != 2'd3) begin
              check($sformatf("gap dut%0d", id), 32'(start_cyc - prev_end), 32'(e[13:12]));
            end
          end
        end
        prev_end = start_cyc + nbits * BD;
      end
    end
  endtask

  initial begin
    fork
      monitor(2'd0, 10);
      monitor(2'd1, 11);
      monitor(2'd2, 11);
      monitor(2'd3, 10);
    join_none
  end

  task automatic wait_drain(input logic [1:0] id, input int max_cycles);
    int n = 0;
    while ((pending(id) != 0 || busy_v[id]) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("drain timeout dut%0d", id), 32'(n >= max_cycles), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  // Driver: one write sampled by the next rising edge; returns at the
  // falling edge just after that edge.
  task automatic write_byte(input int id, input logic [7:0] b);
    @(negedge clk);
    wr_en_v[id] = 1'b1;
    din_v[id]   = b;
    @(negedge clk);
    wr_en_v[id] = 1'b0;
  endtask

  int busy_cnt [4];
  int low_cnt;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 4; i++) begin
      rst_n_v[i] = 1'b0;
      wr_en_v[i] = 1'b0;
      din_v[i]   = 8'h00;
    end
    repeat (3) @(negedge clk);
    check("reset tx", 32'(tx_v[0]), 32'd1);
    check("reset busy", 32'(busy_v[0]), 32'd0);
    check("reset full", 32'(full_v[0]), 32'd0);
    check("reset empty", 32'(empty_v[0]), 32'd1);
    check("reset overflow", 32'(overflow_v[0]), 32'd0);
    for (int i = 0; i < 4; i++) rst_n_v[i] = 1'b1;
    repeat (2) @(negedge clk);

    // 0x55 8N1: 0, 1010_1010 LSB first, 1.
    push_exp(2'd0, 2'd3, 12'h2AA);
    write_byte(0, 8'h55);
    busy_cnt[0] = 0;
    for (int i = 0; i < 300; i++) begin
      if (i == 0) begin
        check("tx after edge N", 32'(tx_v[0]), 32'd1);
        check("empty after write", 32'(empty_v[0]), 32'd0);
      end
      if (i == 1) begin
        check("tx after edge N+1", 32'(tx_v[0]), 32'd1);
        check("empty after pop", 32'(empty_v[0]), 32'd1);
      end
      if (i == 2) check("tx after edge N+2", 32'(tx_v[0]), 32'd0);
      if (busy_v[0]) busy_cnt[0]++;
      @(negedge clk);
    end
    check("busy length 8N1", 32'(busy_cnt[0]), 32'd160);

    // 0x07: even parity bit 1, odd parity bit 0; 0xFF with 7 data bits, 2 stop.
    push_exp(2'd1, 2'd3, 12'h60E);
    push_exp(2'd2, 2'd3, 12'h40E);
    push_exp(2'd3, 2'd3, 12'h3FE);
    @(negedge clk);
    for (int i = 1; i < 4; i++) wr_en_v[i] = 1'b1;
    din_v[1] = 8'h07;
    din_v[2] = 8'h07;
    din_v[3] = 8'hFF;
    @(negedge clk);
    for (int i = 1; i < 4; i++) wr_en_v[i] = 1'b0;
    for (int i = 1; i < 4; i++) busy_cnt[i] = 0;
    for (int i = 0; i < 300; i++) begin
      for (int j = 1; j < 4; j++) if (busy_v[j]) busy_cnt[j]++;
      @(negedge clk);
    end
    check("busy length even", 32'(busy_cnt[1]), 32'd176);
    check("busy length odd", 32'(busy_cnt[2]), 32'd176);
    check("busy length 7N2", 32'(busy_cnt[3]), 32'd160);

    // Ten writes on consecutive cycles: first is popped at once, 2..9 fill
    // the FIFO, the tenth overflows.
    wait_drain(2'd0, 500);
    for (int k = 1; k <= 9; k++) begin
      push_exp(2'd0, (k == 1) ? 2'd3 : 2'd0, frame_8n1(8'(8'h30 + k)));
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 9) check("not full after 8 writes", 32'(full_v[0]), 32'd0);
      if (k == 10) begin
        check("full after 9 writes", 32'(full_v[0]), 32'd1);
        check("no overflow before drop", 32'(overflow_v[0]), 32'd0);
      end
      wr_en_v[0] = 1'b1;
      din_v[0]   = 8'(8'h30 + k);
    end
    @(negedge clk);
    wr_en_v[0] = 1'b0;
    check("overflow pulse", 32'(overflow_v[0]), 32'd1);
    check("still full", 32'(full_v[0]), 32'd1);
    @(negedge clk);
    check("overflow one cycle", 32'(overflow_v[0]), 32'd0);
    wait_drain(2'd0, 2500);

    // Write on the last clock of the stop bit: one idle clock before restart.
    push_exp(2'd0, 2'd3, frame_8n1(8'hA3));
    push_exp(2'd0, 2'd1, frame_8n1(8'h5C));
    write_byte(0, 8'hA3);
    repeat (160) @(negedge clk);
    wr_en_v[0] = 1'b1;
    din_v[0]   = 8'h5C;
    @(negedge clk);
    wr_en_v[0] = 1'b0;
    wait_drain(2'd0, 500);

    // One clock earlier: the stop bit chains straight into the next start.
    push_exp(2'd0, 2'd3, frame_8n1(8'hC6));
    push_exp(2'd0, 2'd0, frame_8n1(8'h19));
    write_byte(0, 8'hC6);
    repeat (159) @(negedge clk);
    wr_en_v[0] = 1'b1;
    din_v[0]   = 8'h19;
    @(negedge clk);
    wr_en_v[0] = 1'b0;
    wait_drain(2'd0, 500);

    // Reset during data bit 3 truncates the frame for good.
    push_exp(2'd0, 2'd3, frame_8n1(8'h00));
    write_byte(0, 8'h00);
    repeat (70) @(negedge clk);
    #2;
    rst_n_v[0] = 1'b0;
    #1;
    check("tx high at reset", 32'(tx_v[0]), 32'd1);
    check("empty at reset", 32'(empty_v[0]), 32'd1);
    check("busy at reset", 32'(busy_v[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n_v[0] = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!tx_v[0]) low_cnt++;
    end
    check("no frame after reset", 32'(low_cnt), 32'd0);
    check("busy idle after reset", 32'(busy_v[0]), 32'd0);

    check("expectations left", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
